// File: rtl/spi_pkg.sv
// Shared SPI definitions: controller state encoding, frame size and the
// mode-0 sampling level used by both the controller and the peripheral side.
package spi_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      SETUP = 3'd1,
      SHIFT = 3'd2,
      HOLD  = 3'd3,
      GAP   = 3'd4
   } spi_state_e;

   localparam int SPI_FRAME_BITS = 8;

   // Mode 0: SDI/SDO are sampled on the edge that takes SCK to this level.
   localparam logic SPI_SAMPLE_LEVEL = 1'b1;

endpackage

// File: rtl/spi_clk_divider.sv
// Half-period tick generator. Counts 0..TICKS-1 while enabled and pulses
// tick on the terminal count; clr forces the count back to zero.
module spi_clk_divider #(
   parameter int TICKS = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   input  logic clr,
   output logic tick
);

   localparam int CW = $clog2(TICKS + 1);
   localparam logic [CW-1:0] TERM = CW'(TICKS - 1);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   // Next count: clear has priority, otherwise wrap at the terminal count.
   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (en) begin
         cnt_d = (cnt_q == TERM) ? '0 : cnt_q + 1'b1;
      end
   end

   // Count register with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign tick = en && !clr && (cnt_q == TERM);

endmodule

// File: rtl/spi_controller.sv
// SPI mode-0 master: byte stream in/out, MSB first, CSN held low across a
// multi-byte transaction until a byte flagged last has been shifted.
// Optional build macro SPI_CONTROLLER_DEBUG_EN adds a registered debug[7:0]
// bus = {state, bit counter, spi_sck, spi_csn}.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | CSN high, SCK low, SDO 0; waiting for the first byte
// SETUP | CSN low for one half period before the first SCK edge
// SHIFT | 8 bits, each a low half then a high half of SCK
// HOLD  | CSN low between bytes of a transaction, waiting for next byte
// GAP   | CSN high for one half period after the last byte
module spi_controller
   import spi_pkg::*;
#(
   parameter int TICKS_PER_HALF_BIT = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] tx_data,
   input  logic       tx_last,
   input  logic       tx_valid,
   output logic       tx_ready,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   output logic       spi_sck,
   output logic       spi_csn,
   output logic       spi_sdo,
   input  logic       spi_sdi
`ifdef SPI_CONTROLLER_DEBUG_EN
   ,
   output logic [7:0] debug
`endif
);

   spi_state_e state_q, state_d;
   logic [2:0] bit_cnt_q, bit_cnt_d;
   logic       sck_q, sck_d;
   logic       csn_q, csn_d;
   logic       sdo_q, sdo_d;
   logic       rx_valid_q, rx_valid_d;
   logic [7:0] rx_data_q, rx_data_d;
   logic [7:0] tx_sr_q, tx_sr_d;
   logic [7:0] rx_sr_q, rx_sr_d;
   logic       last_q, last_d;

   logic       accept;
   logic       tick;
   logic       div_en;
   logic       div_clr;
   logic       sample_half;
   logic       frame_done;

   assign tx_ready = !rst && ((state_q == IDLE) || (state_q == HOLD));
   assign accept   = tx_valid && tx_ready;

   // The divider only runs in timed states; IDLE/HOLD keep it at zero so
   // every timed state starts a fresh half period.
   assign div_en  = (state_q == SETUP) || (state_q == SHIFT) || (state_q == GAP);
   assign div_clr = !div_en;

   spi_clk_divider #(
      .TICKS (TICKS_PER_HALF_BIT)
   ) u_div (
      .clk  (clk),
      .rst  (rst),
      .en   (div_en),
      .clr  (div_clr),
      .tick (tick)
   );

   // Low half ending means the next SCK edge is the sampling edge.
   assign sample_half = (sck_q != SPI_SAMPLE_LEVEL);
   assign frame_done  = tick && !sample_half &&
                        (bit_cnt_q == 3'(SPI_FRAME_BITS - 1));

   // Next-state and output logic.
   always_comb begin
      state_d    = state_q;
      bit_cnt_d  = bit_cnt_q;
      sck_d      = sck_q;
      csn_d      = csn_q;
      sdo_d      = sdo_q;
      rx_valid_d = 1'b0;
      rx_data_d  = rx_data_q;
      tx_sr_d    = tx_sr_q;
      rx_sr_d    = rx_sr_q;
      last_d     = last_q;

      case (state_q)
         IDLE: begin
            csn_d = 1'b1;
            sck_d = 1'b0;
            sdo_d = 1'b0;
            if (accept) begin
               state_d   = SETUP;
               csn_d     = 1'b0;
               sdo_d     = tx_data[7];
               tx_sr_d   = tx_data;
               last_d    = tx_last;
               bit_cnt_d = 3'd0;
            end
         end

         SETUP: begin
            if (tick) begin
               state_d = SHIFT;
            end
         end

         SHIFT: begin
            if (tick) begin
               if (sample_half) begin
                  sck_d   = 1'b1;
                  rx_sr_d = {rx_sr_q[6:0], spi_sdi};
               end else begin
                  sck_d = 1'b0;
                  if (frame_done) begin
                     rx_data_d  = rx_sr_q;
                     rx_valid_d = 1'b1;
                     bit_cnt_d  = 3'd0;
                     if (last_q) begin
                        state_d = GAP;
                        csn_d   = 1'b1;
                        sdo_d   = 1'b0;
                     end else begin
                        state_d = HOLD;
                     end
                  end else begin
                     bit_cnt_d = bit_cnt_q + 3'd1;
                     sdo_d     = tx_sr_q[6];
                     tx_sr_d   = {tx_sr_q[6:0], 1'b0};
                  end
               end
            end
         end

         HOLD: begin
            sck_d = 1'b0;
            if (accept) begin
               state_d   = SHIFT;
               sdo_d     = tx_data[7];
               tx_sr_d   = tx_data;
               last_d    = tx_last;
               bit_cnt_d = 3'd0;
            end
         end

         GAP: begin
            csn_d = 1'b1;
            sdo_d = 1'b0;
            if (tick) begin
               state_d = IDLE;
            end
         end

         default: begin
            state_d = IDLE;
            csn_d   = 1'b1;
            sck_d   = 1'b0;
            sdo_d   = 1'b0;
         end
      endcase
   end

   // State and datapath registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         bit_cnt_q  <= 3'd0;
         sck_q      <= 1'b0;
         csn_q      <= 1'b1;
         sdo_q      <= 1'b0;
         rx_valid_q <= 1'b0;
         rx_data_q  <= 8'h00;
         tx_sr_q    <= 8'h00;
         rx_sr_q    <= 8'h00;
         last_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         bit_cnt_q  <= bit_cnt_d;
         sck_q      <= sck_d;
         csn_q      <= csn_d;
         sdo_q      <= sdo_d;
         rx_valid_q <= rx_valid_d;
         rx_data_q  <= rx_data_d;
         tx_sr_q    <= tx_sr_d;
         rx_sr_q    <= rx_sr_d;
         last_q     <= last_d;
      end
   end

   assign spi_sck  = sck_q;
   assign spi_csn  = csn_q;
   assign spi_sdo  = sdo_q;
   assign rx_data  = rx_data_q;
   assign rx_valid = rx_valid_q;

`ifdef SPI_CONTROLLER_DEBUG_EN
   logic [7:0] debug_q;

   // Debug bus tracks the same cycle as the registered SPI outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         debug_q <= 8'h00;
      end else begin
         debug_q <= {state_d, bit_cnt_d, sck_d, csn_d};
      end
   end

   assign debug = debug_q;
`endif

endmodule

// File: tb/tb_spi_controller.sv
// Bench for spi_controller: a waveform-timeline model predicts CSN/SCK/SDO,
// tx_ready, rx_valid and rx_data per cycle; directed checks pin the model.
module tb_spi_controller;

   localparam int T = 2;

   logic       clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst = 1'b1;
   logic [7:0] tx_data = 8'h00;
   logic       tx_last = 1'b0;
   logic       tx_valid = 1'b0;
   logic       tx_ready;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       spi_sck, spi_csn, spi_sdo, spi_sdi;
   logic       sdi_loop = 1'b1;

   assign spi_sdi = sdi_loop ? spi_sdo : 1'b1;

   spi_controller #(.TICKS_PER_HALF_BIT(T)) dut (
      .clk(clk), .rst(rst), .tx_data(tx_data), .tx_last(tx_last),
      .tx_valid(tx_valid), .tx_ready(tx_ready), .rx_data(rx_data),
      .rx_valid(rx_valid), .spi_sck(spi_sck), .spi_csn(spi_csn),
      .spi_sdo(spi_sdo), .spi_sdi(spi_sdi)
   );

   logic [7:0] tx1_data = 8'h00;
   logic       tx1_last = 1'b0;
   logic       tx1_valid = 1'b0;
   logic       tx1_ready;
   logic [7:0] rx1_data;
   logic       rx1_valid;
   logic       sck1, csn1, sdo1, sdi1;

   assign sdi1 = sdo1;

   spi_controller #(.TICKS_PER_HALF_BIT(1)) dut1 (
      .clk(clk), .rst(rst), .tx_data(tx1_data), .tx_last(tx1_last),
      .tx_valid(tx1_valid), .tx_ready(tx1_ready), .rx_data(rx1_data),
      .rx_valid(rx1_valid), .spi_sck(sck1), .spi_csn(csn1),
      .spi_sdo(sdo1), .spi_sdi(sdi1)
   );

   typedef struct packed {
      logic       csn;
      logic       sck;
      logic       sdo;
      logic       rdy;
      logic       rxv;
      logic [7:0] rxd;
   } exp_t;

   exp_t       q[$];
   logic       rest_hold = 1'b0;
   logic       hold_sdo = 1'b0;
   logic [7:0] exp_rxd = 8'h00;

   int n_cmp = 0;
   int n_bad = 0;
   int cyc = 0;

   int         csn_low_cnt = 0, rxv_cnt = 0, sck_high_cnt = 0, csn_rise_cnt = 0;
   logic [7:0] last_rxd = 8'h00, sdo_rise = 8'h00;
   logic       prev_sck = 1'b0, prev_csn = 1'b1;
   int         rxv1_cnt = 0, n_rise1 = 0, rise1_a = 0, rise1_b = 0;
   logic [7:0] last_rxd1 = 8'h00;
   logic       prev_sck1 = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
      end
   endtask

   task automatic push(input logic c, input logic s, input logic o,
                       input logic r, input logic v, input logic [7:0] d);
      exp_t e;
      e.csn = c; e.sck = s; e.sdo = o; e.rdy = r; e.rxv = v; e.rxd = d;
      q.push_back(e);
   endtask

   // Expected timeline for one accepted byte, starting the cycle after acceptance.
   task automatic push_byte(input logic [7:0] d, input logic l, input logic from_idle);
      logic [7:0] rx;
      rx = sdi_loop ? d : 8'hFF;
      if (from_idle) for (int k = 0; k < T; k++) push(1'b0, 1'b0, d[7], 1'b0, 1'b0, 8'h00);
      for (int b = 7; b >= 0; b--) begin
         for (int k = 0; k < T; k++) push(1'b0, 1'b0, d[b], 1'b0, 1'b0, 8'h00);
         for (int k = 0; k < T; k++) push(1'b0, 1'b1, d[b], 1'b0, 1'b0, 8'h00);
      end
      if (l) begin
         push(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, rx);
         for (int k = 1; k < T; k++) push(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
         rest_hold = 1'b0;
      end else begin
         push(1'b0, 1'b0, d[0], 1'b1, 1'b1, rx);
         rest_hold = 1'b1;
         hold_sdo  = d[0];
      end
   endtask

   task automatic send(input logic [7:0] d, input logic l);
      bit ok;
      ok = 1'b0;
      tx_data = d; tx_last = l; tx_valid = 1'b1;
      for (int i = 0; i < 200 && !ok; i++) begin
         @(negedge clk);
         if (tx_ready === 1'b1) ok = 1'b1;
      end
      if (!ok) begin
         n_cmp++; n_bad++;
         $display("FAIL handshake_timeout at cycle %0d: tx_ready never 1 for byte %0h", cyc, d);
      end
      @(posedge clk); #1;
      tx_valid = 1'b0;
   endtask

   task automatic send1(input logic [7:0] d, input logic l);
      bit ok;
      ok = 1'b0;
      tx1_data = d; tx1_last = l; tx1_valid = 1'b1;
      for (int i = 0; i < 200 && !ok; i++) begin
         @(negedge clk);
         if (tx1_ready === 1'b1) ok = 1'b1;
      end
      if (!ok) begin
         n_cmp++; n_bad++;
         $display("FAIL handshake1_timeout at cycle %0d: tx_ready never 1 for byte %0h", cyc, d);
      end
      @(posedge clk); #1;
      tx1_valid = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      fork
         // Model update on each active edge.
         forever begin : model_proc
            logic cur_rdy;
            @(posedge clk);
            cyc++;
            if (rst) begin
               q.delete();
               rest_hold = 1'b0;
               hold_sdo  = 1'b0;
               exp_rxd   = 8'h00;
            end else begin
               cur_rdy = (q.size() == 0) ? 1'b1 : q[0].rdy;
               if (q.size() != 0) void'(q.pop_front());
               if (tx_valid && cur_rdy) push_byte(tx_data, tx_last, !rest_hold);
               if (q.size() != 0 && q[0].rxv) exp_rxd = q[0].rxd;
            end
         end

         // Compare and monitor away from the active edge.
         forever begin : cmp_proc
            exp_t e;
            @(negedge clk);
            if (rst) begin
               chk("tx_ready_in_rst", tx_ready, 1'b0);
            end else begin
               if (q.size() != 0)  e = q[0];
               else if (rest_hold) e = '{csn:1'b0, sck:1'b0, sdo:hold_sdo, rdy:1'b1, rxv:1'b0, rxd:8'h00};
               else                e = '{csn:1'b1, sck:1'b0, sdo:1'b0, rdy:1'b1, rxv:1'b0, rxd:8'h00};
               chk("spi_csn",  spi_csn,  e.csn);
               chk("spi_sck",  spi_sck,  e.sck);
               chk("spi_sdo",  spi_sdo,  e.sdo);
               chk("tx_ready", tx_ready, e.rdy);
               chk("rx_valid", rx_valid, e.rxv);
               chk("rx_data",  rx_data,  exp_rxd);
            end
            if (spi_csn === 1'b0) csn_low_cnt++;
            if (spi_sck === 1'b1) sck_high_cnt++;
            if (spi_csn === 1'b1 && prev_csn === 1'b0) csn_rise_cnt++;
            if (rx_valid === 1'b1) begin rxv_cnt++; last_rxd = rx_data; end
            if (spi_sck === 1'b1 && prev_sck === 1'b0) sdo_rise = {sdo_rise[6:0], spi_sdo};
            prev_sck = spi_sck;
            prev_csn = spi_csn;
            if (rx1_valid === 1'b1) begin rxv1_cnt++; last_rxd1 = rx1_data; end
            if (sck1 === 1'b1 && prev_sck1 === 1'b0) begin
               if (n_rise1 == 0) rise1_a = cyc;
               else if (n_rise1 == 1) rise1_b = cyc;
               n_rise1++;
            end
            prev_sck1 = sck1;
         end

         begin : stim_proc
            int b_csn, b_rxv, b_sck, b_crise;
            repeat (3) @(posedge clk);
            #1 rst = 1'b0;
            @(negedge clk);
            chk("reset_csn", spi_csn, 1'b1);
            chk("reset_rx_data", rx_data, 8'h00);
            @(posedge clk); #1;

            // Single byte, loopback.
            sdi_loop = 1'b1;
            b_csn = csn_low_cnt; b_rxv = rxv_cnt;
            send(8'hA5, 1'b1);
            repeat (45) @(posedge clk); #1;
            chk("t1_csn_low_cycles", csn_low_cnt - b_csn, 34);
            chk("t1_rx_pulses", rxv_cnt - b_rxv, 1);
            chk("t1_rx_data", last_rxd, 8'hA5);
            chk("t1_sdo_at_rise", sdo_rise, 8'hA5);

            // Three-byte transaction, SDI tied high.
            sdi_loop = 1'b0;
            b_csn = csn_low_cnt; b_rxv = rxv_cnt; b_crise = csn_rise_cnt;
            send(8'h01, 1'b0);
            send(8'h80, 1'b0);
            send(8'hFF, 1'b1);
            repeat (45) @(posedge clk); #1;
            chk("t2_csn_low_cycles", csn_low_cnt - b_csn, 100);
            chk("t2_rx_pulses", rxv_cnt - b_rxv, 3);
            chk("t2_rx_data", last_rxd, 8'hFF);
            chk("t2_csn_rises", csn_rise_cnt - b_crise, 1);

            // HOLD stall for 50 cycles.
            sdi_loop = 1'b1;
            send(8'h96, 1'b0);
            repeat (40) @(posedge clk); #1;
            b_csn = csn_low_cnt; b_sck = sck_high_cnt;
            repeat (50) @(posedge clk); #1;
            chk("t3_stall_csn_low", csn_low_cnt - b_csn, 50);
            chk("t3_stall_sck_high", sck_high_cnt - b_sck, 0);
            b_rxv = rxv_cnt; b_sck = sck_high_cnt;
            send(8'h69, 1'b1);
            repeat (45) @(posedge clk); #1;
            chk("t3_rx_pulses", rxv_cnt - b_rxv, 1);
            chk("t3_rx_data", last_rxd, 8'h69);
            chk("t3_sck_high_cycles", sck_high_cnt - b_sck, 16);

            // Backpressure with changing data during SHIFT.
            b_rxv = rxv_cnt;
            send(8'hC7, 1'b0);
            for (int i = 0; i < 20; i++) begin
               tx_data  = 8'($urandom);
               tx_last  = 1'($urandom);
               tx_valid = 1'b1;
               @(negedge clk);
               chk("t4_ready_low_busy", tx_ready, 1'b0);
               @(posedge clk); #1;
            end
            send(8'h5A, 1'b1);
            repeat (45) @(posedge clk); #1;
            chk("t4_rx_pulses", rxv_cnt - b_rxv, 2);
            chk("t4_rx_data", last_rxd, 8'h5A);

            // Reset mid-byte after 3 bits.
            send(8'hC3, 1'b1);
            repeat (14) @(posedge clk);
            #1 rst = 1'b1;
            @(posedge clk);
            #1 rst = 1'b0;
            @(negedge clk);
            chk("t5_csn_after_rst", spi_csn, 1'b1);
            chk("t5_sck_after_rst", spi_sck, 1'b0);
            chk("t5_sdo_after_rst", spi_sdo, 1'b0);
            chk("t5_rxv_after_rst", rx_valid, 1'b0);
            b_rxv = rxv_cnt;
            repeat (40) @(posedge clk); #1;
            chk("t5_no_rx_pulse", rxv_cnt - b_rxv, 0);
            send(8'h5C, 1'b1);
            repeat (45) @(posedge clk); #1;
            chk("t5_rx_pulses", rxv_cnt - b_rxv, 1);
            chk("t5_rx_data", last_rxd, 8'h5C);

            // One tick per half bit, loopback.
            b_rxv = rxv1_cnt;
            send1(8'h3C, 1'b1);
            for (int i = 0; i < 60 && rxv1_cnt == b_rxv; i++) @(posedge clk);
            repeat (10) @(posedge clk); #1;
            chk("t6_rx_pulses", rxv1_cnt - b_rxv, 1);
            chk("t6_rx_data", last_rxd1, 8'h3C);
            chk("t6_sck_period", rise1_b - rise1_a, 2);
            chk("t6_sck_rises", n_rise1, 8);
         end
      join_any

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
